sync_fifo_param: RTL and testbench

//  Single-clock, parametrised FIFO; successor to the team's async FIFO for same-domain buffering.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/sync_fifo_mem.sv | 42 ++++
 rtl/sync_fifo_param.sv | 120 ++++++++++++
 tb/tb_sync_fifo_param.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: depth calculation, parameter
// legality predicates and the packed status-flag bundle.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

  function automatic bit afull_ok(input int thresh, input int aw);
    return (thresh >= 1) && (thresh <= depth(aw) - 1);
  endfunction

  function automatic bit aempty_ok(input int thresh, input int aw);
    return (thresh >= 0) && (thresh <= depth(aw) - 2);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for the synchronous FIFO: synchronous write port, and either a
// registered read port or a combinational head-of-queue read (FWFT).
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:depth(ADDR_WIDTH)-1];

  // NOTE: the array has no reset; empty/full come from the pointers, so stale
  // contents are never observable and the array can map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  if (FWFT != 0) begin : g_fwft
    logic w_unused_fwft;
    assign w_unused_fwft = ^{i_rst, i_re};
    assign o_rdata       = r_mem[i_raddr];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] r_rdata;
    // Holds the last popped word; rejected reads leave it untouched.
    always_ff @(posedge i_clk) begin
      if (i_rst)     r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
    end
    assign o_rdata = r_rdata;
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags and optional FWFT read mode.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = depth(ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);

  if (ADDR_WIDTH < 1) begin : g_bad_aw
    $error("sync_fifo_param: ADDR_WIDTH must be >= 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_dw
    $error("sync_fifo_param: DATA_WIDTH must be >= 1");
  end
  if (!afull_ok(AFULL_THRESH, ADDR_WIDTH)) begin : g_bad_afull
    $error("sync_fifo_param: AFULL_THRESH must be in 1..DEPTH-1");
  end
  if (!aempty_ok(AEMPTY_THRESH, ADDR_WIDTH)) begin : g_bad_aempty
    $error("sync_fifo_param: AEMPTY_THRESH must be in 0..DEPTH-2");
  end
  if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  // Extra MSB is the wrap bit; it separates full from empty when addresses match.
  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t AFULL_P  = ptr_t'(AFULL_THRESH);
  localparam ptr_t AEMPTY_P = ptr_t'(AEMPTY_THRESH);

  ptr_t        r_wptr;
  ptr_t        r_rptr;
  ptr_t        w_count;
  fifo_flags_t w_flags;
  logic        w_wr_en;
  logic        w_rd_en;
  logic        r_overflow;
  logic        r_underflow;

  assign w_count = r_wptr - r_rptr;

  always_comb begin
    w_flags.empty        = (r_wptr == r_rptr);
    w_flags.full         = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                           (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
    w_flags.almost_full  = (w_count >= AFULL_P);
    w_flags.almost_empty = (w_count <= AEMPTY_P);
  end

  assign w_wr_en = winc && !w_flags.full;
  assign w_rd_en = rinc && !w_flags.empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the pointers and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + ptr_t'(1);
      if (w_rd_en) r_rptr <= r_rptr + ptr_t'(1);
    end
  end

  // Setting an error takes priority over clearing it in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (winc && w_flags.full) r_overflow <= 1'b1;
      else if (clr_err)         r_overflow <= 1'b0;
      if (rinc && w_flags.empty) r_underflow <= 1'b1;
      else if (clr_err)          r_underflow <= 1'b0;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FWFT       (FWFT)
  ) u_mem (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_wr_en),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (wdata),
    .i_re    (w_rd_en),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (rdata)
  );

  assign wfull         = w_flags.full;
  assign rempty        = w_flags.empty;
  assign walmost_full  = w_flags.almost_full;
  assign ralmost_empty = w_flags.almost_empty;
  assign count         = w_count;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a queue-based reference model checked every cycle
// against a registered-read and an FWFT instance, plus directed literal checks.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wdata = '0;

  logic          wfull0, wafull0, rempty0, raempty0, ovf0, unf0;
  logic          wfull1, wafull1, rempty1, raempty1, ovf1, unf1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW:0]   count0, count1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull0),
    .walmost_full(wafull0), .rinc(rinc), .rdata(rdata0), .rempty(rempty0),
    .ralmost_empty(raempty0), .count(count0), .clr_err(clr_err),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull1),
    .walmost_full(wafull1), .rinc(rinc), .rdata(rdata1), .rempty(rempty1),
    .ralmost_empty(raempty1), .count(count1), .clr_err(clr_err),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue, flags from its size.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata0 = '0;
  bit            m_ovf = 0;
  bit            m_unf = 0;
  bit            model_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rdata0    = '0;
      m_ovf       = 0;
      m_unf       = 0;
      model_valid = 1;
    end else begin
      automatic bit was_full  = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
      if (rinc && !was_empty) m_rdata0 = q.pop_front();
      if (winc && !was_full)  q.push_back(wdata);
      if (winc && was_full) m_ovf = 1;
      else if (clr_err)     m_ovf = 0;
      if (rinc && was_empty) m_unf = 1;
      else if (clr_err)      m_unf = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_valid) begin
      automatic int n = q.size();
      check("count0", 32'(count0), 32'(n));
      check("count1", 32'(count1), 32'(n));
      check("rempty0", 32'(rempty0), 32'(n == 0));
      check("rempty1", 32'(rempty1), 32'(n == 0));
      check("wfull0", 32'(wfull0), 32'(n == DEPTH));
      check("wfull1", 32'(wfull1), 32'(n == DEPTH));
      check("walmost_full0", 32'(wafull0), 32'(n >= DEPTH - 2));
      check("walmost_full1", 32'(wafull1), 32'(n >= DEPTH - 2));
      check("ralmost_empty0", 32'(raempty0), 32'(n <= 2));
      check("ralmost_empty1", 32'(raempty1), 32'(n <= 2));
      check("overflow0", 32'(ovf0), 32'(m_ovf));
      check("overflow1", 32'(ovf1), 32'(m_ovf));
      check("underflow0", 32'(unf0), 32'(m_unf));
      check("underflow1", 32'(unf1), 32'(m_unf));
      check("rdata0", 32'(rdata0), 32'(m_rdata0));
      if (n != 0) check("rdata1_head", 32'(rdata1), 32'(q[0]));
    end
  end

  // One clock cycle: inputs set at the falling edge, results sampled 1 after the rising edge.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                     input logic c, input logic rs);
    @(negedge clk);
    winc = w; wdata = d; rinc = r; clr_err = c; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d); cyc(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic rd();   cyc(1'b0, '0, 1'b1, 1'b0, 1'b0); endtask
  task automatic idle(); cyc(1'b0, '0, 1'b0, 1'b0, 1'b0); endtask
  task automatic clr();  cyc(1'b0, '0, 1'b0, 1'b1, 1'b0); endtask

  initial begin
    // Reset
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle();
    check("rst_rempty", 32'(rempty0), 32'd1);
    check("rst_wfull", 32'(wfull0), 32'd0);
    check("rst_count", 32'(count0), 32'd0);
    check("rst_overflow", 32'(ovf0), 32'd0);
    check("rst_underflow", 32'(unf0), 32'd0);
    check("rst_rdata", 32'(rdata0), 32'd0);
    check("rst_ralmost_empty", 32'(raempty0), 32'd1);
    check("rst_walmost_full", 32'(wafull0), 32'd0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      check("fill_count", 32'(count0), 32'(i + 1));
      check("fill_walmost_full", 32'(wafull0), 32'(i + 1 >= 14));
    end
    check("fill_wfull", 32'(wfull0), 32'd1);

    // Overflow: rejected write keeps count and contents
    wr(8'hEE);
    check("ovf_flag", 32'(ovf0), 32'd1);
    check("ovf_count", 32'(count0), 32'd16);

    // Drain: data 1 cycle after each rinc, in order
    for (int i = 0; i < 16; i++) begin
      rd();
      check("drain_rdata", 32'(rdata0), 32'(i));
    end
    check("drain_rempty", 32'(rempty0), 32'd1);

    // Underflow, rdata held on rejected read, then clear
    rd();
    check("unf_flag", 32'(unf0), 32'd1);
    check("unf_rdata_hold", 32'(rdata0), 32'h0F);
    clr();
    check("clr_overflow", 32'(ovf0), 32'd0);
    check("clr_underflow", 32'(unf0), 32'd0);

    // Simultaneous access at count=5
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'h15 + 8'(i), 1'b1, 1'b0, 1'b0);
      check("simul_count", 32'(count0), 32'd5);
      check("simul_rdata", 32'(rdata0), 32'(8'h10 + 8'(i)));
    end
    for (int i = 0; i < 5; i++) begin
      rd();
      check("simul_tail", 32'(rdata0), 32'(8'h1A + 8'(i)));
    end

    // Simultaneous on full, then on empty
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
    cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    check("full_simul_count", 32'(count0), 32'd15);
    check("full_simul_rdata", 32'(rdata0), 32'h80);
    check("full_simul_ovf", 32'(ovf0), 32'd1);
    for (int i = 0; i < 15; i++) rd();
    check("full_simul_last", 32'(rdata0), 32'h8F);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    check("empty_simul_count", 32'(count0), 32'd1);
    check("empty_simul_unf", 32'(unf0), 32'd1);
    rd();
    check("empty_simul_rdata", 32'(rdata0), 32'h5A);
    clr();

    // Wrap-around: 40 words streamed, occupancy kept between 3 and 7
    begin
      automatic int n_wr = 0;
      automatic int n_rd = 0;
      automatic int i = 0;
      for (int k = 0; k < 5; k++) begin
        wr(8'h40 + 8'(n_wr));
        n_wr++;
      end
      while (n_wr < 40) begin
        automatic logic w = (i % 3 != 2);
        automatic logic r = (i % 3 != 0);
        cyc(w, 8'h40 + 8'(n_wr), r, 1'b0, 1'b0);
        if (w) n_wr++;
        if (r) begin
          check("wrap_rdata", 32'(rdata0), 32'(8'h40 + 8'(n_rd)));
          n_rd++;
        end
        check("wrap_count_range", 32'(count0 >= 3 && count0 <= 7), 32'd1);
        i++;
      end
      while (n_rd < 40) begin
        rd();
        check("wrap_drain", 32'(rdata0), 32'(8'h40 + 8'(n_rd)));
        n_rd++;
      end
      check("wrap_empty", 32'(rempty0), 32'd1);
    end

    // FWFT head word visible without rinc
    wr(8'hA5);
    check("fwft_rempty", 32'(rempty1), 32'd0);
    check("fwft_rdata", 32'(rdata1), 32'hA5);
    rd();
    check("fwft_after_pop", 32'(rempty1), 32'd1);

    // Reset mid-operation at count=9
    for (int i = 0; i < 9; i++) wr(8'hC0 + 8'(i));
    check("mid_count_pre", 32'(count0), 32'd9);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("mid_rst_count", 32'(count0), 32'd0);
    check("mid_rst_rempty", 32'(rempty0), 32'd1);
    wr(8'h3C);
    check("mid_fwft_rdata", 32'(rdata1), 32'h3C);
    rd();
    check("mid_new_word", 32'(rdata0), 32'h3C);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
